hex_window_scanner: RTL and testbench

- Parametrised successor to the fixed 16-bit hash-window mux plus 4-digit segment driver.
- Captures a wide data word, e.g. a 256-bit SHA-256 digest, and shows it on a DIGITS-wide multiplexed seven-segment display, one window at a time.
- Supports manual window select or auto-scroll through all windows.
- Contains its own scan-tick divider, digit-scan counter and hex decoder; drives board cathodes and anodes directly.

---
 rtl/hex_window_scanner.sv | 161 ++++++++++++++++
 tb/tb_hex_window_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_window_scanner.sv
// Wide-word viewer for a multiplexed seven-segment display: one DIGITS-wide hex window at a time, manual or auto-scroll.
// Optional build macro WINDOW_INDEX_DP_EN lights decimal points as a binary readout of the shown window index.
module hex_window_scanner #(
    parameter int DATA_W       = 256,
    parameter int DIGITS       = 4,
    parameter int DIV          = 100000,
    parameter int SCROLL_TICKS = 50000,
    localparam int WINDOWS     = DATA_W / (4 * DIGITS),
    localparam int SEL_W       = (WINDOWS > 1) ? $clog2(WINDOWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    input  logic              mode,
    input  logic              pause,
    input  logic [SEL_W-1:0]  sel,
    output logic [7:0]        segment_cathodes,
    output logic [DIGITS-1:0] digit_anodes,
    output logic [SEL_W-1:0]  window_idx,
    output logic              wrap
);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCR_W   = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIBBLES = WINDOWS * DIGITS;
    localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SCR_W-1:0] SCR_LAST  = SCR_W'(SCROLL_TICKS - 1);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);
    localparam logic [SEL_W-1:0] WIN_LAST  = SEL_W'(WINDOWS - 1);
    localparam logic             MULTI_WIN = (WINDOWS > 1);

    logic [DATA_W-1:0] data_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [SCR_W-1:0]  scroll_cnt_reg;
    logic [DIG_W-1:0]  digit_reg;
    logic [SEL_W-1:0]  window_idx_reg;
    logic [7:0]        segment_cathodes_reg;
    logic [DIGITS-1:0] digit_anodes_reg;
    logic              wrap_reg;

    logic              tick;
    logic [SEL_W-1:0]  sel_clamped;
    logic [NIB_W-1:0]  nibble_sel;
    logic [3:0]        nibble_cur;
    logic [6:0]        seg_next;
    logic              dp_next;
    logic [3:0]        nibbles [NIBBLES];

    assign tick = (div_cnt_reg == DIV_LAST);

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign nibbles[gi] = data_reg[gi*4 +: 4];
        end
        // A full power-of-two select range cannot exceed the last window.
        if (WINDOWS == (2 ** SEL_W)) begin : g_sel_full
            assign sel_clamped = sel;
        end else begin : g_sel_clamp
            assign sel_clamped = (sel > WIN_LAST) ? WIN_LAST : sel;
        end
    endgenerate

    assign nibble_sel = NIB_W'(window_idx_reg) * NIB_W'(DIGITS) + NIB_W'(digit_reg);
    assign nibble_cur = nibbles[nibble_sel];

    // Active-low {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
    always_comb begin
        seg_next = 7'h7F;
        case (nibble_cur)
            4'h0: seg_next = 7'h40;
            4'h1: seg_next = 7'h79;
            4'h2: seg_next = 7'h24;
            4'h3: seg_next = 7'h30;
            4'h4: seg_next = 7'h19;
            4'h5: seg_next = 7'h12;
            4'h6: seg_next = 7'h02;
            4'h7: seg_next = 7'h78;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h10;
            4'hA: seg_next = 7'h08;
            4'hB: seg_next = 7'h03;
            4'hC: seg_next = 7'h46;
            4'hD: seg_next = 7'h21;
            4'hE: seg_next = 7'h06;
            4'hF: seg_next = 7'h0E;
            default: seg_next = 7'h7F;
        endcase
    end

`ifdef WINDOW_INDEX_DP_EN
    logic [DIGITS-1:0] win_bits;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dp
            if (gi < SEL_W) begin : g_bit
                assign win_bits[gi] = window_idx_reg[gi];
            end else begin : g_zero
                assign win_bits[gi] = 1'b0;
            end
        end
    endgenerate
    assign dp_next = ~win_bits[digit_reg];
`else
    assign dp_next = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg             <= '0;
            div_cnt_reg          <= '0;
            scroll_cnt_reg       <= '0;
            digit_reg            <= '0;
            window_idx_reg       <= '0;
            segment_cathodes_reg <= 8'hFF;
            digit_anodes_reg     <= '1;
            wrap_reg             <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (load) begin
                data_reg <= data_in;
            end

            // Display outputs change only on a tick, so a load never glitches the current digit.
            if (tick) begin
                div_cnt_reg          <= '0;
                digit_anodes_reg     <= ~(DIGITS'(1) << digit_reg);
                segment_cathodes_reg <= {dp_next, seg_next};
                digit_reg            <= (digit_reg == DIG_LAST) ? '0 : digit_reg + DIG_W'(1);
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end

            if (!mode) begin
                window_idx_reg <= sel_clamped;
                scroll_cnt_reg <= '0;
            end else if (load) begin
                window_idx_reg <= '0;
                scroll_cnt_reg <= '0;
            end else if (tick && !pause) begin
                if (scroll_cnt_reg == SCR_LAST) begin
                    scroll_cnt_reg <= '0;
                    if (window_idx_reg == WIN_LAST) begin
                        window_idx_reg <= '0;
                        wrap_reg       <= MULTI_WIN;
                    end else begin
                        window_idx_reg <= window_idx_reg + SEL_W'(1);
                    end
                end else begin
                    scroll_cnt_reg <= scroll_cnt_reg + SCR_W'(1);
                end
            end
        end
    end

    assign segment_cathodes = segment_cathodes_reg;
    assign digit_anodes     = digit_anodes_reg;
    assign window_idx       = window_idx_reg;
    assign wrap             = wrap_reg;
endmodule

// File: tb/tb_hex_window_scanner.sv
// Bench for hex_window_scanner: directed steps plus random traffic, checked against a cycle-count reference model.
module tb_hex_window_scanner;
    localparam int DATA_W       = 32;
    localparam int DIGITS       = 4;
    localparam int DIV          = 4;
    localparam int SCROLL_TICKS = 2;
    localparam int WINDOWS      = DATA_W / (4 * DIGITS);
    localparam int SEL_W        = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              load = 1'b0;
    logic              mode = 1'b0;
    logic              pause = 1'b0;
    logic [SEL_W-1:0]  sel = '0;
    logic [7:0]        segment_cathodes;
    logic [DIGITS-1:0] digit_anodes;
    logic [SEL_W-1:0]  window_idx;
    logic              wrap;

    int total = 0;
    int bad   = 0;

    hex_window_scanner #(
        .DATA_W(DATA_W), .DIGITS(DIGITS), .DIV(DIV), .SCROLL_TICKS(SCROLL_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .mode(mode), .pause(pause),
        .sel(sel), .segment_cathodes(segment_cathodes), .digit_anodes(digit_anodes),
        .window_idx(window_idx), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Reference model: time is a posedge count since reset, windows and digits are plain integers.
    logic [DATA_W-1:0] m_data;
    int                m_win, m_scroll, m_digit, m_cyc;
    logic [7:0]        e_cat;
    logic [DIGITS-1:0] e_an;
    logic              e_wrap;

    function automatic string glyph(input int v);
        case (v)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";   3: return "abcdg";
            4: return "bcfg";     5: return "acdfg";   6: return "acdefg";  7: return "abc";
            8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
            12: return "adef";    13: return "bcdeg";  14: return "adefg";  default: return "aefg";
        endcase
    endfunction

    function automatic logic [7:0] cathode_for(input logic [DATA_W-1:0] d, input int w, input int dig);
        logic [6:0] segs;
        string      s;
        int         nib;
        logic       dp;
        segs = 7'h7F;
        nib  = int'((d >> ((w * DIGITS + dig) * 4)) & DATA_W'(15));
        s    = glyph(nib);
        for (int i = 0; i < s.len(); i++) begin
            segs = segs & ~(7'(1) << (int'(s[i]) - 97));
        end
        dp = 1'b1;
`ifdef WINDOW_INDEX_DP_EN
        if (dig < SEL_W && ((w >> dig) & 1) == 1) dp = 1'b0;
`endif
        return {dp, segs};
    endfunction

    task automatic model_reset();
        m_data = '0; m_win = 0; m_scroll = 0; m_digit = 0; m_cyc = 0;
        e_cat = 8'hFF; e_an = '1; e_wrap = 1'b0;
    endtask

    task automatic model_edge();
        bit tick;
        if (!rst) begin
            model_reset();
            return;
        end
        tick   = (m_cyc % DIV) == DIV - 1;
        e_wrap = 1'b0;
        if (tick) begin
            e_an    = ~(DIGITS'(1) << m_digit);
            e_cat   = cathode_for(m_data, m_win, m_digit);
            m_digit = (m_digit + 1) % DIGITS;
        end
        if (!mode) begin
            m_win    = (int'(sel) > WINDOWS - 1) ? WINDOWS - 1 : int'(sel);
            m_scroll = 0;
        end else if (load) begin
            m_win    = 0;
            m_scroll = 0;
        end else if (tick && !pause) begin
            m_scroll++;
            if (m_scroll == SCROLL_TICKS) begin
                m_scroll = 0;
                m_win    = (m_win + 1) % WINDOWS;
                e_wrap   = (m_win == 0) && (WINDOWS > 1);
            end
        end
        if (load) m_data = data_in;
        m_cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cathodes", 32'(segment_cathodes), 32'(e_cat));
        check("anodes", 32'(digit_anodes), 32'(e_an));
        check("window_idx", 32'(window_idx), 32'(m_win));
        check("wrap", 32'(wrap), 32'(e_wrap));
    endtask

    task automatic wait_anode(input logic [DIGITS-1:0] target);
        int n;
        n = 0;
        while (digit_anodes !== target && n < 40) begin
            step();
            n++;
        end
        check("anode_wait", 32'(digit_anodes), 32'(target));
    endtask

    initial begin
        int n;
        int changes;
        logic [SEL_W-1:0]  saved_win;
        logic [DIGITS-1:0] prev_an;
        logic [7:0]        sel1_digit0;

        model_reset();
        repeat (3) step();
        check("reset_cathodes", 32'(segment_cathodes), 32'hFF);
        check("reset_anodes", 32'(digit_anodes), 32'hF);

        rst = 1'b1;
        repeat (DIV - 1) step();
        check("pre_tick_anodes", 32'(digit_anodes), 32'hF);
        check("pre_tick_cathodes", 32'(segment_cathodes), 32'hFF);
        step();
        check("first_anode", 32'(digit_anodes), 32'b1110);
        check("first_zero", 32'(segment_cathodes), 32'hC0);

        data_in = 32'h1234ABCD;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_anode(4'b0111);
        wait_anode(4'b1110);
        check("manual_d0", 32'(segment_cathodes), 32'hA1);
        wait_anode(4'b1101);
        check("manual_d1", 32'(segment_cathodes), 32'hC6);
        wait_anode(4'b1011);
        check("manual_d2", 32'(segment_cathodes), 32'h83);
        wait_anode(4'b0111);
        check("manual_d3", 32'(segment_cathodes), 32'h88);

        sel = 1'b1;
        step();
        check("sel1_window", 32'(window_idx), 32'd1);
        wait_anode(4'b0111);
        wait_anode(4'b1110);
`ifdef WINDOW_INDEX_DP_EN
        sel1_digit0 = 8'h19;
`else
        sel1_digit0 = 8'h99;
`endif
        check("sel1_d0", 32'(segment_cathodes), 32'(sel1_digit0));

        sel = 1'b0;
        repeat (2) step();
        mode = 1'b1;
        n = 0;
        while (window_idx !== 1'b1 && n < 40) begin step(); n++; end
        check("auto_advance", 32'(window_idx), 32'd1);
        n = 0;
        while (wrap !== 1'b1 && n < 40) begin step(); n++; end
        check("auto_wrap_seen", 32'(wrap), 32'd1);
        check("auto_wrap_window", 32'(window_idx), 32'd0);
        step();
        check("wrap_one_cycle", 32'(wrap), 32'd0);

        pause = 1'b1;
        saved_win = window_idx;
        prev_an = digit_anodes;
        changes = 0;
        for (int i = 0; i < 10 * DIV; i++) begin
            step();
            check("pause_hold", 32'(window_idx), 32'(saved_win));
            if (digit_anodes !== prev_an) changes++;
            prev_an = digit_anodes;
        end
        check("pause_scan", 32'(changes), 32'd10);
        pause = 1'b0;

        // Line up a load with the edge that would wrap window 1 back to 0.
        n = 0;
        while (!(m_win == 1 && m_scroll == SCROLL_TICKS - 1 && (m_cyc % DIV) == DIV - 1) && n < 100) begin
            step();
            n++;
        end
        check("collision_found", 32'(n < 100), 32'd1);
        data_in = 32'hCAFEF00D;
        load = 1'b1;
        step();
        load = 1'b0;
        check("collision_window", 32'(window_idx), 32'd0);
        check("collision_wrap", 32'(wrap), 32'd0);
        mode = 1'b0;
        sel = 1'b0;
        wait_anode(4'b0111);
        wait_anode(4'b1110);
        check("collision_data", 32'(segment_cathodes), 32'hA1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            if ($urandom_range(0, 23) == 0) pause = ~pause;
            sel = SEL_W'($urandom_range(0, 1));
            load = ($urandom_range(0, 15) == 0);
            data_in = DATA_W'($urandom);
            step();
        end
        load = 1'b0;

        mode = 1'b0;
        pause = 1'b0;
        sel = 1'b1;
        step();
        wait_anode(4'b1011);
        #1 rst = 1'b0;
        #1;
        check("async_cathodes", 32'(segment_cathodes), 32'hFF);
        check("async_anodes", 32'(digit_anodes), 32'hF);
        check("async_window", 32'(window_idx), 32'd0);
        check("async_wrap", 32'(wrap), 32'd0);
        model_reset();
        repeat (3) step();
        rst = 1'b1;
        repeat (2 * DIV) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
